dds_sweep_ctrl: RTL

Frequency-sweep controller placed directly upstream of the multi-cycle DDS. It drives the DDS frequency word, frequency-load strobe and work enable. It steps the frequency word linearly from a start value to a stop value, holding each value for a programmable number of DDS samples, at a programmable sample rate. It supports single-shot and continuous (wrapping) sweeps for stimulus and chirp generation.

---
 rtl/dds_sweep_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller feeding a multi-cycle DDS.
// Steps FREQOUT from start to stop by step, holding each word for dwell
// DDS samples issued every div clocks; single-shot or wrapping sweeps.
module dds_sweep_ctrl #(
    parameter int FW = 32,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CFGWE,
    input  logic [1:0]    CFGADDR,
    input  logic [31:0]   CFGDATA,
    input  logic          MODE,
    input  logic          START,
    input  logic          STOP,
    output logic [FW-1:0] FREQOUT,
    output logic          FREQEN,
    output logic          DDSEN,
    output logic          BUSY,
    output logic          DONE
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, STEP, FINISH} state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] cfg_start_q, cfg_start_d, cfg_stop_q, cfg_stop_d, cfg_step_q, cfg_step_d;
    logic [CW-1:0] cfg_dwell_q, cfg_dwell_d, cfg_div_q, cfg_div_d;
    logic [FW-1:0] sh_start_q, sh_start_d, sh_stop_q, sh_stop_d, sh_step_q, sh_step_d;
    logic [CW-1:0] sh_dwell_q, sh_dwell_d, sh_div_q, sh_div_d;
    logic          sh_mode_q, sh_mode_d;
    logic [CW-1:0] pulse_cnt_q, pulse_cnt_d, div_cnt_q, div_cnt_d;
    logic [FW-1:0] freqout_q, freqout_d;
    logic          freqen_q, freqen_d, ddsen_q, ddsen_d, busy_q, busy_d, done_q, done_d;
    logic [FW:0]   next_sum;

    // Config register file, writable in any state.
    always_comb begin
        cfg_start_d = cfg_start_q;
        cfg_stop_d  = cfg_stop_q;
        cfg_step_d  = cfg_step_q;
        cfg_dwell_d = cfg_dwell_q;
        cfg_div_d   = cfg_div_q;
        if (CFGWE) begin
            unique case (CFGADDR)
                2'd0: cfg_start_d = CFGDATA[FW-1:0];
                2'd1: cfg_stop_d  = CFGDATA[FW-1:0];
                2'd2: cfg_step_d  = CFGDATA[FW-1:0];
                2'd3: begin
                    cfg_div_d   = CFGDATA[16 +: CW];
                    cfg_dwell_d = CFGDATA[0 +: CW];
                end
                default: ;
            endcase
        end
    end

    // Next-state and registered-output logic; outputs are computed one
    // cycle ahead so every output pin comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        sh_start_d  = sh_start_q;
        sh_stop_d   = sh_stop_q;
        sh_step_d   = sh_step_q;
        sh_dwell_d  = sh_dwell_q;
        sh_div_d    = sh_div_q;
        sh_mode_d   = sh_mode_q;
        pulse_cnt_d = pulse_cnt_q;
        div_cnt_d   = div_cnt_q;
        freqout_d   = freqout_q;
        freqen_d    = 1'b0;
        ddsen_d     = 1'b0;
        done_d      = 1'b0;
        next_sum    = {1'b0, freqout_q} + {1'b0, sh_step_q};

        unique case (state_q)
            IDLE: begin
                if (START && !STOP) begin
                    state_d    = LOAD;
                    sh_start_d = cfg_start_q;
                    sh_stop_d  = cfg_stop_q;
                    sh_step_d  = cfg_step_q;
                    sh_dwell_d = (cfg_dwell_q == '0) ? CW'(1) : cfg_dwell_q;
                    sh_div_d   = (cfg_div_q == '0) ? CW'(1) : cfg_div_q;
                    sh_mode_d  = MODE;
                    freqout_d  = cfg_start_q;
                    freqen_d   = 1'b1;
                end
            end
            LOAD, STEP: begin
                state_d     = RUN;
                ddsen_d     = 1'b1;
                pulse_cnt_d = CW'(1);
                div_cnt_d   = '0;
            end
            RUN: begin
                // The step decision is made in the dwell-th pulse cycle so the
                // new word appears on the very next cycle.
                if (ddsen_q && (pulse_cnt_q == sh_dwell_q)) begin
                    if (!next_sum[FW] && (next_sum[FW-1:0] <= sh_stop_q)) begin
                        state_d   = STEP;
                        freqout_d = next_sum[FW-1:0];
                        freqen_d  = 1'b1;
                    end else if (sh_mode_q) begin
                        state_d   = STEP;
                        freqout_d = sh_start_q;
                        freqen_d  = 1'b1;
                    end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end
                end else if (div_cnt_q == (sh_div_q - CW'(1))) begin
                    ddsen_d     = 1'b1;
                    div_cnt_d   = '0;
                    pulse_cnt_d = pulse_cnt_q + CW'(1);
                end else begin
                    div_cnt_d = div_cnt_q + CW'(1);
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (STOP && (state_q != IDLE)) begin
            state_d   = IDLE;
            freqen_d  = 1'b0;
            ddsen_d   = 1'b0;
            done_d    = 1'b0;
            freqout_d = freqout_q;
        end

        busy_d = (state_d == LOAD) || (state_d == RUN) || (state_d == STEP);
    end

    // State, config, shadow, counter and output registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            cfg_start_q <= '0;
            cfg_stop_q  <= '0;
            cfg_step_q  <= '0;
            cfg_dwell_q <= '0;
            cfg_div_q   <= '0;
            sh_start_q  <= '0;
            sh_stop_q   <= '0;
            sh_step_q   <= '0;
            sh_dwell_q  <= '0;
            sh_div_q    <= '0;
            sh_mode_q   <= 1'b0;
            pulse_cnt_q <= '0;
            div_cnt_q   <= '0;
            freqout_q   <= '0;
            freqen_q    <= 1'b0;
            ddsen_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_start_q <= cfg_start_d;
            cfg_stop_q  <= cfg_stop_d;
            cfg_step_q  <= cfg_step_d;
            cfg_dwell_q <= cfg_dwell_d;
            cfg_div_q   <= cfg_div_d;
            sh_start_q  <= sh_start_d;
            sh_stop_q   <= sh_stop_d;
            sh_step_q   <= sh_step_d;
            sh_dwell_q  <= sh_dwell_d;
            sh_div_q    <= sh_div_d;
            sh_mode_q   <= sh_mode_d;
            pulse_cnt_q <= pulse_cnt_d;
            div_cnt_q   <= div_cnt_d;
            freqout_q   <= freqout_d;
            freqen_q    <= freqen_d;
            ddsen_q     <= ddsen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign FREQOUT = freqout_q;
    assign FREQEN  = freqen_q;
    assign DDSEN   = ddsen_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule
